dmem_responder: RTL and testbench

Data-memory responder serving the stage-4 load/store port of the RV32I pipeline. It is the target end of the Memrdy handshake.
- Accepts one request at a time.
- Models a fixed-latency word-organised SRAM with byte/half/word access, sign/zero extension and byte-lane write merging.
- Holds rdy low while an access is in flight, so the core's global halt freezes the pipeline until the access completes.

---
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the Memrdy handshake for the stage-4 load/store port.
//   Models a fixed-latency, word-organised SRAM with byte/half/word access,
//   sign/zero extension on loads and byte-lane merging on stores. Holds rdy
//   low while an access is in flight so the core's global halt freezes the
//   pipeline until the access completes.
//
//   Optional feature macro: DMEM_MISALIGN_TRAP_EN
//     defined   -> err port present; misaligned accesses do not write the
//                  array and load 0; err is high during DONE only.
//     undefined -> no err port; misaligned accesses are forced aligned.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   req_valid     stage 4 presents a load or store
//   req_write     1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  zero-extend loads when 1
//   rdy           no access pending, or access completing (Memrdy)
//   rdata         extended load result, valid in DONE and held afterwards
//   err           misaligned-access flag (DMEM_MISALIGN_TRAP_EN only)
//
// State | Meaning
// IDLE  | no access pending; rdy follows ~req_valid
// BUSY  | access in flight, counter counts remaining stall cycles
// DONE  | access completing; rdy high for this one cycle

module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rdy,
    output logic [31:0] rdata
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    logic [3:0]     counter;

    logic           lat_write;
    logic           lat_unsigned;
    logic [AW+1:0]  lat_addr;
    logic [31:0]    lat_wdata;
    logic [1:0]     lat_size;

    logic [31:0]    mem [DEPTH];

    // Access actually being completed this cycle. In IDLE the live request is
    // used so that a single-cycle configuration can commit on the accept edge.
    logic           a_write;
    logic           a_unsigned;
    logic [AW+1:0]  a_addr;
    logic [31:0]    a_wdata;
    logic [1:0]     a_size;
    logic [AW-1:0]  a_idx;
    logic           commit;
    logic           mis;
    logic [31:0]    rd_word;
    logic [31:0]    wr_word;
    logic [31:0]    load_val;
    logic [7:0]     byte_val;
    logic [15:0]    half_val;

    // Upper address bits wrap modulo DEPTH and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign rdy = ((state == IDLE) && !req_valid) || (state == DONE);

    always_comb begin
        if (state == IDLE) begin
            a_write    = req_write;
            a_unsigned = req_unsigned;
            a_addr     = req_addr[AW+1:0];
            a_wdata    = req_wdata;
            a_size     = req_size;
        end else begin
            a_write    = lat_write;
            a_unsigned = lat_unsigned;
            a_addr     = lat_addr;
            a_wdata    = lat_wdata;
            a_size     = lat_size;
        end
    end

    assign a_idx  = a_addr[AW+1:2];
    assign commit = ((state == IDLE) && req_valid && (WAIT_CYCLES == 1)) ||
                    ((state == BUSY) && (counter == 4'd0));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = ((a_size == 2'b01) && a_addr[0]) ||
                 (a_size[1] && (a_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign rd_word  = mem[a_idx];
    // Half ignores addr[0] and word ignores addr[1:0], which aligns any
    // misaligned access when the trap is not built in.
    assign byte_val = rd_word[{a_addr[1:0], 3'b000} +: 8];
    assign half_val = rd_word[{a_addr[1], 4'b0000} +: 16];

    always_comb begin
        wr_word = rd_word;
        case (a_size)
            2'b00:   wr_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            2'b01:   wr_word[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            default: wr_word = a_wdata;
        endcase
    end

    always_comb begin
        case (a_size)
            2'b00:   load_val = a_unsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   load_val = a_unsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_val = rd_word;
        endcase
    end

    // Array is not reset; an access abandoned by reset never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && a_write && !mis) begin
            mem[a_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= 4'd0;
            rdata        <= 32'd0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
            err          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr[AW+1:0];
                        lat_wdata    <= req_wdata;
                        lat_size     <= req_size;
                        if (WAIT_CYCLES == 1) begin
                            state <= DONE;
                        end else begin
                            counter <= CNT_INIT;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        state <= DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (commit && !a_write) begin
                rdata <= mis ? 32'd0 : load_val;
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            // commit always leads into DONE, so err is high exactly there.
            err <= commit && mis;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rdy;
    logic [31:0] rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Byte-addressed reference memory
    logic [7:0]  mb [4*DEPTH];
    logic [31:0] exp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rdy(rdy),
        .rdata(rdata)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic err_now();
`ifdef DMEM_MISALIGN_TRAP_EN
        return err;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_mis(logic [31:0] a, logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_nbytes(logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int model_first(logic [31:0] a, logic [1:0] sz);
        int wi;
        int off;
        wi  = int'({2'b00, a[31:2]}) % DEPTH;
        off = (sz == 2'b00) ? int'(a[1:0]) : (sz == 2'b01) ? (int'(a[1:0]) & 2) : 0;
        return wi * 4 + off;
    endfunction

    function automatic void model_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        int fb;
        if (model_mis(a, sz)) return;
        fb = model_first(a, sz);
        for (int i = 0; i < model_nbytes(sz); i++) mb[fb + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic u);
        logic [31:0] v;
        int fb;
        if (model_mis(a, sz)) return 32'd0;
        fb = model_first(a, sz);
        v = 32'd0;
        for (int i = 0; i < model_nbytes(sz); i++) v[8*i +: 8] = mb[fb + i];
        if (sz == 2'b00 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 2'b01 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after
    // the rising edge that leaves DONE, with req_valid low.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic u,
                          output logic [31:0] rd, output int lat,
                          output logic er, output logic er_early);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = u;
        lat = 0; er_early = 1'b0;
        @(negedge clk);
        while (!rdy && lat < 64) begin
            er_early = er_early | err_now();
            lat++;
            @(posedge clk); #1;
            // Live inputs must be ignored once the access is latched.
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr = $urandom; req_wdata = $urandom;
            req_size = 2'($urandom_range(0, 3));
            req_unsigned = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rd = rdata;
        er = err_now();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        tests_run++; if (rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        tests_run++; if (err_now() !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_now()); end
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (rdy !== 1'b1 || rdata !== 32'd0) begin tests_failed++; $display("FAIL idle_hold: rdy %b rdata %h want 1 0", rdy, rdata); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; int lat; logic er, ee;
        access(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (lat !== WAIT) begin tests_failed++; $display("FAIL sw_latency: got %0d want %0d", lat, WAIT); end
        access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (lat !== WAIT) begin tests_failed++; $display("FAIL lw_latency: got %0d want %0d", lat, WAIT); end
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_word: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; int lat; logic er, ee;
        access(1'b1, 32'h100, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        access(1'b1, 32'h101, 32'h80, 2'b00, 1'b0, rd, lat, er, ee);
        access(1'b0, 32'h101, 32'h0, 2'b00, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb: got %h want ffffff80", rd); end
        access(1'b0, 32'h101, 32'h0, 2'b00, 1'b1, rd, lat, er, ee);
        tests_run++; if (rd !== 32'h00000080) begin tests_failed++; $display("FAIL lbu: got %h want 00000080", rd); end
        access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== 32'h00008000) begin tests_failed++; $display("FAIL lw_after_sb: got %h want 00008000", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; int lat; logic er, ee;
        access(1'b1, 32'h200, 32'hCAFEF00D, 2'b10, 1'b0, rd, lat, er, ee);
        access(1'b1, 32'h202, 32'h1234, 2'b01, 1'b0, rd, lat, er, ee);
        access(1'b0, 32'h202, 32'h0, 2'b01, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== 32'h00001234) begin tests_failed++; $display("FAIL lh: got %h want 00001234", rd); end
        access(1'b0, 32'h200, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== 32'h1234F00D) begin tests_failed++; $display("FAIL lw_after_sh: got %h want 1234f00d", rd); end
        access(1'b1, 32'h204, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== 32'h1234F00D) begin tests_failed++; $display("FAIL store_keeps_rdata: got %h want 1234f00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic er, ee;
        access(1'b1, 32'h40, 32'h11111111, 2'b10, 1'b0, rd, lat, er, ee);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
        req_wdata = 32'h55AA55AA; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        #2;
        tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_rdy: got %b want 1", rdy); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++; if (rdy !== 1'b1 || rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_release: rdy %b rdata %h want 1 0", rdy, rdata); end
        @(posedge clk); #1;
        access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== 32'h11111111) begin tests_failed++; $display("FAIL reset_abandon: got %h want 11111111", rd); end
        tests_run++; if (lat !== WAIT) begin tests_failed++; $display("FAIL reset_latency: got %0d want %0d", lat, WAIT); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; int lat; logic er, ee;
        logic [31:0] exp_w, exp_h;
        logic        exp_e;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_w = 32'h11111111; exp_h = 32'h0; exp_e = 1'b1;
`else
        exp_w = 32'hA5A5A5A5; exp_h = 32'hFFFFA5A5; exp_e = 1'b0;
`endif
        access(1'b1, 32'h43, 32'hA5A5A5A5, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (er !== exp_e || ee !== 1'b0) begin tests_failed++; $display("FAIL sw_mis_err: done %b busy %b want %b 0", er, ee, exp_e); end
        tests_run++; if (lat !== WAIT) begin tests_failed++; $display("FAIL sw_mis_latency: got %0d want %0d", lat, WAIT); end
        @(negedge clk);
        tests_run++; if (err_now() !== 1'b0) begin tests_failed++; $display("FAIL err_after_done: got %b want 0", err_now()); end
        @(posedge clk); #1;
        access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== exp_w) begin tests_failed++; $display("FAIL sw_mis_mem: got %h want %h", rd, exp_w); end
        access(1'b0, 32'h43, 32'h0, 2'b01, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== exp_h || er !== exp_e) begin tests_failed++; $display("FAIL lh_mis: got %h/%b want %h/%b", rd, er, exp_h, exp_e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d, a; int lat; logic er, ee;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            a = 32'h380 + 32'(4 * i);
            access(1'b1, a, d, 2'b10, 1'b0, rd, lat, er, ee);
            access(1'b0, a, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
            tests_run++; if (rd !== d || lat !== WAIT) begin tests_failed++; $display("FAIL raw_b2b: got %h lat %0d want %h lat %0d", rd, lat, d, WAIT); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, a, exp; int lat; logic er, ee, w, u; logic [1:0] sz;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            a = 32'hC00 + 32'(4 * i);
            model_store(a, d, 2'b10);
            access(1'b1, a, d, 2'b10, 1'b0, rd, lat, er, ee);
        end
        exp_rdata = model_load(32'hC00, 2'b10, 1'b0);
        access(1'b0, 32'hC00, 32'h0, 2'b10, 1'b0, rd, lat, er, ee);
        tests_run++; if (rd !== exp_rdata) begin tests_failed++; $display("FAIL rnd_seed_load: got %h want %h", rd, exp_rdata); end
        for (int n = 0; n < 300; n++) begin
            a = ($urandom & ~32'(4 * DEPTH - 1)) | (32'hC00 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)));
            d = $urandom;
            sz = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (w) model_store(a, d, sz);
            else exp_rdata = model_load(a, sz, u);
            access(w, a, d, sz, u, rd, lat, er, ee);
            tests_run++;
            if (rd !== exp_rdata || lat !== WAIT || er !== model_mis(a, sz) || ee !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd_access w=%b a=%h sz=%0d u=%b: rdata %h lat %0d err %b/%b want %h %0d %b/0",
                         w, a, sz, u, rd, lat, er, ee, exp_rdata, WAIT, model_mis(a, sz));
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
